iter_alu: RTL and testbench

Parametrised multi-cycle ALU with built-in operation decode. It accepts raw aluop/func3/func7 fields plus operands over a valid/ready handshake. Logic and add/compare operations complete in one cycle; shifts iterate one bit per cycle and multiply iterates shift-add over XLEN cycles. It replaces the combinational ALU-control path in the execute stage and adds SRA, SLT, SLTU and MUL, with back-pressure to the core.

---
 rtl/iter_alu.sv | 193 +++++++++++++++++++
 tb/tb_iter_alu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// Multi-cycle ALU with integrated aluop/func3/func7 decode: single-cycle logic/add/compare,
// bit-serial shifts and shift-add multiply behind a valid/ready handshake.
module iter_alu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      aluop,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [3:0]      alucontrol
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    // The counter must hold XLEN itself for the multiply loop.
    localparam int CNT_W = SHW + 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;

    state_t            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [XLEN-1:0]   result_q;
    logic [3:0]        alucontrol_q;
    logic [XLEN-1:0]   acc_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [3:0]        op_d;
    logic [XLEN-1:0]   alu_res_d;
    logic [XLEN-1:0]   shift_step_d;
    logic [XLEN-1:0]   mul_sum_d;
    logic [SHW-1:0]    shamt;
    logic              is_shift;

    assign shamt    = b[SHW-1:0];
    assign is_shift = (op_d == OP_SLL) || (op_d == OP_SRL) || (op_d == OP_SRA);

    always_comb begin
        op_d = OP_ADD;
        case (aluop)
            2'b00: op_d = OP_ADD;
            2'b01: op_d = OP_SUB;
            2'b10: begin
                case ({func7, func3})
                    10'b0000000_000: op_d = OP_ADD;
                    10'b0100000_000: op_d = OP_SUB;
                    10'b0000000_111: op_d = OP_AND;
                    10'b0000000_110: op_d = OP_OR;
                    10'b0000000_100: op_d = OP_XOR;
                    10'b0000000_001: op_d = OP_SLL;
                    10'b0000000_101: op_d = OP_SRL;
                    10'b0100000_101: op_d = OP_SRA;
                    10'b0000000_010: op_d = OP_SLT;
                    10'b0000000_011: op_d = OP_SLTU;
                    10'b0000001_000: op_d = OP_MUL;
                    default:         op_d = OP_ADD;
                endcase
            end
            default: begin
                case (func3)
                    3'b000:  op_d = OP_ADD;
                    3'b010:  op_d = OP_SLT;
                    3'b011:  op_d = OP_SLTU;
                    3'b100:  op_d = OP_XOR;
                    3'b110:  op_d = OP_OR;
                    3'b111:  op_d = OP_AND;
                    3'b001:  op_d = OP_SLL;
                    default: op_d = func7[5] ? OP_SRA : OP_SRL;
                endcase
            end
        endcase
    end

    // Shifts land here only with shamt==0, where the result is simply a.
    always_comb begin
        alu_res_d = a;
        case (op_d)
            OP_AND:  alu_res_d = a & b;
            OP_OR:   alu_res_d = a | b;
            OP_XOR:  alu_res_d = a ^ b;
            OP_ADD:  alu_res_d = a + b;
            OP_SUB:  alu_res_d = a - b;
            OP_SLT:  alu_res_d = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res_d = {{(XLEN-1){1'b0}}, (a < b)};
            default: alu_res_d = a;
        endcase
    end

    always_comb begin
        shift_step_d = {1'b0, acc_q[XLEN-1:1]};
        case (alucontrol_q)
            OP_SLL:  shift_step_d = {acc_q[XLEN-2:0], 1'b0};
            OP_SRA:  shift_step_d = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
            default: shift_step_d = {1'b0, acc_q[XLEN-1:1]};
        endcase
    end

    assign mul_sum_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            alucontrol_q <= OP_ADD;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        alucontrol_q <= op_d;
                        in_ready_q   <= 1'b0;
                        if (op_d == OP_MUL) begin
                            state_q  <= S_MUL;
                            acc_q    <= '0;
                            mcand_q  <= a;
                            mplier_q <= b;
                            cnt_q    <= CNT_W'(XLEN);
                        end else if (is_shift && (shamt != '0)) begin
                            state_q <= S_SHIFT;
                            acc_q   <= a;
                            cnt_q   <= {1'b0, shamt};
                        end else begin
                            state_q     <= S_DONE;
                            result_q    <= alu_res_d;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    acc_q <= shift_step_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= S_DONE;
                        result_q    <= shift_step_d;
                        out_valid_q <= 1'b1;
                    end
                end
                S_MUL: begin
                    acc_q    <= mul_sum_d;
                    mcand_q  <= {mcand_q[XLEN-2:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[XLEN-1:1]};
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= S_DONE;
                        result_q    <= mul_sum_d;
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign zero       = (result_q == '0);
    assign alucontrol = alucontrol_q;

endmodule

// File: tb/tb_iter_alu.sv
// Randomized and directed bench for iter_alu against a behavioural decode/arithmetic model.
module tb_iter_alu;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      aluop;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] a, b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic [3:0]      alucontrol;

    int n_checks = 0;
    int n_fail   = 0;

    iter_alu #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .func3(func3), .func7(func7), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .alucontrol(alucontrol)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [2:0] f3,
                                              input logic [6:0] f7);
        if (op == 2'd0) return 4'd2;
        if (op == 2'd1) return 4'd6;
        if (op == 2'd2) begin
            case ({f7, f3})
                10'b0000000_000: return 4'd2;
                10'b0100000_000: return 4'd6;
                10'b0000000_111: return 4'd0;
                10'b0000000_110: return 4'd1;
                10'b0000000_100: return 4'd3;
                10'b0000000_001: return 4'd4;
                10'b0000000_101: return 4'd5;
                10'b0100000_101: return 4'd7;
                10'b0000000_010: return 4'd8;
                10'b0000000_011: return 4'd9;
                10'b0000001_000: return 4'd10;
                default:         return 4'd2;
            endcase
        end
        case (f3)
            3'b000: return 4'd2;
            3'b010: return 4'd8;
            3'b011: return 4'd9;
            3'b100: return 4'd3;
            3'b110: return 4'd1;
            3'b111: return 4'd0;
            3'b001: return 4'd4;
            default: return f7[5] ? 4'd7 : 4'd5;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] ref_result(input logic [3:0] op, input logic [XLEN-1:0] x,
                                                   input logic [XLEN-1:0] y);
        int sh = int'(y[4:0]);
        case (op)
            4'd0:  return x & y;
            4'd1:  return x | y;
            4'd2:  return x + y;
            4'd3:  return x ^ y;
            4'd4:  return x << sh;
            4'd5:  return x >> sh;
            4'd6:  return x - y;
            4'd7:  return XLEN'($signed(x) >>> sh);
            4'd8:  return ($signed(x) < $signed(y)) ? 1 : 0;
            4'd9:  return (x < y) ? 1 : 0;
            default: return XLEN'(64'(x) * 64'(y));
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [XLEN-1:0] y);
        if (op == 4'd10) return 1 + XLEN;
        if (op == 4'd4 || op == 4'd5 || op == 4'd7) return 1 + int'(y[4:0]);
        return 1;
    endfunction

    // Called at #1 after a rising edge; returns at #1 after the edge that leaves DONE.
    task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [XLEN-1:0] x, input logic [XLEN-1:0] y, input int hold);
        logic [3:0]      eop = ref_decode(op, f3, f7);
        logic [XLEN-1:0] eres = ref_result(eop, x, y);
        int              elat = ref_latency(eop, y);
        int              lat;
        logic            busy_ok = 1'b1;
        check("idle_ready", in_ready, 1);
        aluop = op; func3 = f3; func7 = f7; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(elat));
        check("busy_ready_low", busy_ok, 1);
        check("result", result, eres);
        check("zero", zero, (eres == 0));
        check("alucontrol", alucontrol, eop);
        $display("txn aluop=%b f7_f3=%b_%b a=%h b=%h op=%0d result=%h lat=%0d",
                 op, f7, f3, x, y, eop, result, lat);
        for (int i = 0; i < hold; i++) begin
            if (i == 3) begin
                in_valid = 1'b1; aluop = 2'b01; a = ~x; b = y;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("hold_result", result, eres);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_ctrl", alucontrol, eop);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
    endtask

    task automatic reset_checks();
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_ctrl", alucontrol, 4'b0010);
    endtask

    initial begin
        logic [9:0] rcodes [11] = '{10'b0000000_000, 10'b0100000_000, 10'b0000000_111,
                                    10'b0000000_110, 10'b0000000_100, 10'b0000000_001,
                                    10'b0000000_101, 10'b0100000_101, 10'b0000000_010,
                                    10'b0000000_011, 10'b0000001_000};
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        aluop = 2'b00; func3 = 3'b000; func7 = 7'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks();
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'b10, 3'b000, 7'b0000000, 32'd5, 32'd7, 0);
        run_op(2'b01, 3'b000, 7'b0000000, 32'h1234, 32'h1234, 0);
        run_op(2'b10, 3'b111, 7'b1111111, 32'h10, 32'h20, 0);
        run_op(2'b11, 3'b101, 7'b0100000, 32'h80000000, 32'd4, 0);
        run_op(2'b11, 3'b101, 7'b0100000, 32'h80000000, 32'd0, 0);
        run_op(2'b10, 3'b000, 7'b0000001, 32'hFFFFFFFF, 32'd3, 0);
        run_op(2'b10, 3'b010, 7'b0000000, 32'hFFFFFFFF, 32'd1, 10);
        run_op(2'b10, 3'b011, 7'b0000000, 32'hFFFFFFFF, 32'd1, 0);
        run_op(2'b11, 3'b001, 7'b0000000, 32'h00000001, 32'd31, 0);

        // Reset in the middle of a multiply must discard it silently.
        aluop = 2'b10; func3 = 3'b000; func7 = 7'b0000001; a = 32'h1234; b = 32'h5678;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid_mul_valid", out_valid, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        reset_checks();
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", out_valid, 0);
        run_op(2'b00, 3'b000, 7'b0000000, 32'd100, 32'd23, 0);

        for (int t = 0; t < 40; t++) begin
            logic [1:0] op = 2'($urandom_range(0, 3));
            logic [9:0] code = 10'($urandom);
            if (op == 2'b10 && $urandom_range(0, 4) != 0) code = rcodes[$urandom_range(0, 10)];
            run_op(op, code[2:0], code[9:3], $urandom, $urandom, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
